// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   localparam int          INSTR_W    = 32;
   localparam int          OPCODE_W   = 11;
   localparam int          OPCODE_LSB = 21;
   localparam int          PC_W       = 64;
   localparam int          WAIT_W     = 16;
   localparam logic [63:0] PC_INC     = 64'd4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection at retire: fall-through or word-scaled branch target.
module next_pc_calc
   import fetch_pkg::*;
(
   input  logic [PC_W-1:0] instr_pc,
   input  logic [PC_W-1:0] ext_imm,
   input  logic            branch,
   input  logic            uncond_branch,
   input  logic            zero,
   output logic [PC_W-1:0] next_pc
);

   logic            taken;
   logic [PC_W-1:0] target;

   // Offset is in words; the shift and add wrap silently modulo 2^64.
   always_comb begin
      taken   = uncond_branch | (branch & zero);
      target  = instr_pc + (ext_imm << 2);
      next_pc = taken ? target : instr_pc + PC_INC;
   end

endmodule

// File: rtl/fetch_unit.sv
// PC holder and single-outstanding req/ack instruction fetcher feeding the decoder.
// Optional fetch timeout fault enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC       = 64'h0,
   parameter int          TIMEOUT_CYCLES = 256
)
(
   input  logic                CLK,
   input  logic                reset,
   output logic                imem_req,
   output logic [PC_W-1:0]     imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [OPCODE_W-1:0] opcode,
   output logic [PC_W-1:0]     instr_pc,
   input  logic                retire,
   input  logic                branch,
   input  logic                uncond_branch,
   input  logic                zero,
   input  logic [PC_W-1:0]     ext_imm,
   output logic                fetch_fault
);

   fetch_state_t    state, state_next;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] next_pc;
   logic            load_instr;
   logic            load_pc;
   logic            timeout_hit;

   next_pc_calc u_next_pc (
      .instr_pc      (instr_pc),
      .ext_imm       (ext_imm),
      .branch        (branch),
      .uncond_branch (uncond_branch),
      .zero          (zero),
      .next_pc       (next_pc)
   );

`ifdef FETCH_TIMEOUT_EN
   logic [WAIT_W-1:0] wait_cnt;

   // Held at zero outside FETCH so every fetch starts counting from zero.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (state != FETCH)
         wait_cnt <= '0;
      else if (!imem_ack)
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
   assign fetch_fault = (state == FAULT);
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
   assign fetch_fault        = 1'b0;
`endif

   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // An ack on the expiry edge completes the fetch instead of faulting.
   always_comb begin
      state_next = state;
      load_instr = 1'b0;
      load_pc    = 1'b0;
      case (state)
         IDLE:  state_next = FETCH;
         FETCH: begin
            if (imem_ack) begin
               state_next = EXEC;
               load_instr = 1'b1;
            end else if (timeout_hit) begin
               state_next = FAULT;
            end
         end
         EXEC: begin
            if (retire) begin
               state_next = FETCH;
               load_pc    = 1'b1;
            end
         end
         FAULT:   state_next = FAULT;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         pc       <= RESET_PC;
         instr    <= '0;
         instr_pc <= RESET_PC;
      end else begin
         if (load_instr) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
         end
         if (load_pc)
            pc <= next_pc;
      end
   end

   assign imem_req    = (state == FETCH);
   assign imem_addr   = pc;
   assign instr_valid = (state == EXEC);
   assign opcode      = instr[OPCODE_LSB +: OPCODE_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised self-checking bench for fetch_unit with a transaction-level PC model.
module tb_fetch_unit;

   localparam logic [63:0] RST_PC = 64'h0;
`ifdef FETCH_TIMEOUT_EN
   localparam int TO_CYC    = 4;
   localparam int LONG_WAIT = 3;
`else
   localparam int TO_CYC    = 256;
   localparam int LONG_WAIT = 5;
`endif

   logic        CLK = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [10:0] opcode;
   logic [63:0] instr_pc;
   logic        retire;
   logic        branch;
   logic        uncond_branch;
   logic        zero;
   logic [63:0] ext_imm;
   logic        fetch_fault;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   logic [63:0] model_pc;

   fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .CLK(CLK), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
      .retire(retire), .branch(branch), .uncond_branch(uncond_branch), .zero(zero),
      .ext_imm(ext_imm), .fetch_fault(fetch_fault)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // One instruction from FETCH back to FETCH; entered and left just after a falling edge.
   task automatic do_instr(input int ad, input int rd, input bit br, input bit unc, input bit z,
                           input logic [63:0] imm, input logic [31:0] w);
      for (int i = 0; i < ad; i++) begin
         n_checks++;
         if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_wait: req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, model_pc);
         end
         imem_ack = 1'b0; imem_rdata = $urandom; retire = 1'($urandom);
         branch = 1'($urandom); uncond_branch = 1'($urandom); zero = 1'($urandom);
         ext_imm = {$urandom, $urandom};
         @(negedge CLK);
      end
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL fetch_req: req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                  imem_req, imem_addr, instr_valid, model_pc);
      end
      imem_ack = 1'b1; imem_rdata = w; retire = 1'($urandom);
      @(negedge CLK);
      for (int i = 0; i < rd; i++) begin
         n_checks++;
         if (instr_valid !== 1'b1 || instr !== w || opcode !== w[31:21] || instr_pc !== model_pc
             || imem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL exec_hold: valid=%b instr=%h op=%h ipc=%h req=%b expected 1 %h %h %h 0",
                     instr_valid, instr, opcode, instr_pc, imem_req, w, w[31:21], model_pc);
         end
         retire = 1'b0; imem_ack = 1'($urandom); imem_rdata = $urandom;
         branch = 1'($urandom); uncond_branch = 1'($urandom); zero = 1'($urandom);
         ext_imm = {$urandom, $urandom};
         @(negedge CLK);
      end
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== w || opcode !== w[31:21] || instr_pc !== model_pc) begin
         n_errors++;
         $display("FAIL exec_capture: valid=%b instr=%h op=%h ipc=%h expected 1 %h %h %h",
                  instr_valid, instr, opcode, instr_pc, w, w[31:21], model_pc);
      end
      retire = 1'b1; branch = br; uncond_branch = unc; zero = z; ext_imm = imm;
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      @(negedge CLK);
      if (unc || (br && z)) model_pc = model_pc + imm * 64'd4;
      else                  model_pc = model_pc + 64'd4;
      retire = 1'b0; imem_ack = 1'b0;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL next_pc: req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                  imem_req, imem_addr, instr_valid, model_pc);
      end
   endtask

   task automatic test_reset();
      @(negedge CLK);
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || opcode !== 11'h0 ||
          instr_pc !== RST_PC || imem_addr !== RST_PC || fetch_fault !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_values: req=%b valid=%b instr=%h op=%h ipc=%h addr=%h fault=%b",
                  imem_req, instr_valid, instr, opcode, instr_pc, imem_addr, fetch_fault);
      end
      imem_ack = 1'b1; imem_rdata = 32'h8B02_0020; reset = 1'b0; model_pc = RST_PC;
      #1;
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_errors++; $display("FAIL idle_after_reset: req=%b expected 0", imem_req);
      end
      @(negedge CLK);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
         n_errors++; $display("FAIL first_req: req=%b addr=%h expected 1 0", imem_req, imem_addr);
      end
      @(negedge CLK);
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h8B02_0020 || opcode !== 11'h458 || instr_pc !== 64'h0) begin
         n_errors++;
         $display("FAIL first_instr: valid=%b instr=%h op=%h ipc=%h expected 1 8b020020 458 0",
                  instr_valid, instr, opcode, instr_pc);
      end
      imem_ack = 1'b0; retire = 1'b1; branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0;
      @(negedge CLK);
      retire = 1'b0;
      model_pc = 64'h4;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin
         n_errors++; $display("FAIL seq_addr4: req=%b addr=%h expected 1 4", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential();
      int start;
      start = cyc;
      do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, $urandom);
      n_checks++;
      if (cyc - start != 2) begin
         n_errors++; $display("FAIL throughput: cycles=%0d expected 2", cyc - start);
      end
      n_checks++;
      if (imem_addr !== 64'h8) begin
         n_errors++; $display("FAIL seq_addr8: addr=%h expected 8", imem_addr);
      end
      do_instr(0, 1, 1'b0, 1'b0, 1'b1, 64'h7, $urandom);
      do_instr(1, 0, 1'b0, 1'b0, 1'b0, 64'h3, $urandom);
   endtask

   task automatic test_branches();
      do_instr(0, 0, 1'b0, 1'b1, 1'b0, -64'sd2, $urandom);
      n_checks++;
      if (imem_addr !== 64'h08) begin
         n_errors++; $display("FAIL b_target: addr=%h expected 8", imem_addr);
      end
      do_instr(0, 2, 1'b1, 1'b0, 1'b0, 64'h5, $urandom);
      n_checks++;
      if (imem_addr !== 64'h0C) begin
         n_errors++; $display("FAIL cbz_not_taken: addr=%h expected c", imem_addr);
      end
      do_instr(0, 0, 1'b1, 1'b0, 1'b1, 64'h3, $urandom);
      n_checks++;
      if (imem_addr !== 64'h18) begin
         n_errors++; $display("FAIL cbz_taken: addr=%h expected 18", imem_addr);
      end
      do_instr(1, 1, 1'b0, 1'b0, 1'b1, 64'h40, $urandom);
   endtask

   task automatic test_ack_wait();
      do_instr(LONG_WAIT, 2, 1'b0, 1'b0, 1'b0, 64'h0, $urandom);
   endtask

   task automatic test_wrap();
      do_instr(0, 0, 1'b0, 1'b1, 1'b0, ~(model_pc >> 2), $urandom);
      n_checks++;
      if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         n_errors++; $display("FAIL wrap_top: addr=%h expected fffffffffffffffc", imem_addr);
      end
      do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, $urandom);
      n_checks++;
      if (imem_addr !== 64'h0) begin
         n_errors++; $display("FAIL wrap_zero: addr=%h expected 0", imem_addr);
      end
      do_instr(0, 0, 1'b1, 1'b0, 1'b1, 64'h0, $urandom);
   endtask

   task automatic test_reset_mid_fetch();
      do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, $urandom);
      imem_ack = 1'b0;
      @(negedge CLK);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || imem_addr !== RST_PC || instr_valid !== 1'b0 || instr !== 32'h0 ||
          instr_pc !== RST_PC || fetch_fault !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset: req=%b addr=%h valid=%b instr=%h ipc=%h fault=%b",
                  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault);
      end
      imem_ack = 1'b1; imem_rdata = $urandom;
      @(negedge CLK);
      reset = 1'b0; model_pc = RST_PC;
      @(negedge CLK);
      n_checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
         n_errors++;
         $display("FAIL stale_ack: valid=%b req=%b addr=%h expected 0 1 %h",
                  instr_valid, imem_req, imem_addr, RST_PC);
      end
      do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, $urandom);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++)
         do_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                  1'($urandom), {{48{1'b0}}, 16'($urandom)} - 64'h8000, $urandom);
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      do_instr(TO_CYC - 1, 0, 1'b0, 1'b0, 1'b0, 64'h0, $urandom);
      imem_ack = 1'b0;
      for (int i = 0; i < TO_CYC; i++) begin
         n_checks++;
         if (imem_req !== 1'b1 || fetch_fault !== 1'b0) begin
            n_errors++; $display("FAIL pre_timeout: req=%b fault=%b expected 1 0", imem_req, fetch_fault);
         end
         @(negedge CLK);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL fault_state: fault=%b req=%b valid=%b expected 1 0 0",
                     fetch_fault, imem_req, instr_valid);
         end
         imem_ack = 1'b1; retire = 1'b1;
         @(negedge CLK);
      end
      retire = 1'b0; reset = 1'b1;
      #1;
      n_checks++;
      if (fetch_fault !== 1'b0) begin
         n_errors++; $display("FAIL fault_clear: fault=%b expected 0", fetch_fault);
      end
      @(negedge CLK);
      reset = 1'b0; model_pc = RST_PC;
      @(negedge CLK);
      do_instr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, $urandom);
   endtask
`endif

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; retire = 1'b0;
      branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0; ext_imm = '0; model_pc = RST_PC;
      test_reset();
      test_sequential();
      test_branches();
      test_ack_wait();
      test_wrap();
      test_reset_mid_fetch();
      test_random();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
